// File: rtl/can_mac_rx_frame_sequencer.sv
// CAN 2.0A receive frame sequencer: walks SOF..EOF on destuffed bits,
// assembles ID/RTR/DLC/DATA, checks CRC-15 and reports frame or error.
//
// Ports:
//   clk, reset_n        clock, async active-low reset
//   can_clk_en          bit-time strobe; state only advances when high
//   rx_enable           receiver enable (also drives ready)
//   bit_in, bit_valid   destuffed bit and its qualifier
//   stuff_error         destuffer stuff-error flag
//   destuffing_enable   stuffing region active (ID..CRC)
//   ready               sequencer accepts bits
//   rx_id/rx_rtr/rx_dlc/rx_data  received fields (byte0 in [63:56])
//   frame_valid         one-clk pulse, good frame
//   error_valid         one-clk pulse, frame aborted, with error_code
//   error_code          1=stuff 2=form 3=crc 4=extended frame
//   ack_slot            high while in the ACK slot after a CRC match
//   busy                high from SOF to frame end or abort
module can_mac_rx_frame_sequencer #(
    parameter int unsigned INTEGRATION_BITS = 11,
    parameter int unsigned EOF_BITS         = 7,
    parameter logic [14:0] CRC_POLY         = 15'h4599
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        can_clk_en,
    input  logic        rx_enable,
    input  logic        bit_in,
    input  logic        bit_valid,
    input  logic        stuff_error,
    output logic        destuffing_enable,
    output logic        ready,
    output logic [10:0] rx_id,
    output logic        rx_rtr,
    output logic [3:0]  rx_dlc,
    output logic [63:0] rx_data,
    output logic        frame_valid,
    output logic        error_valid,
    output logic [2:0]  error_code,
    output logic        ack_slot,
    output logic        busy
);

    typedef enum logic [3:0] {
        S_INTEGRATE,
        S_IDLE,
        S_ID,
        S_RTR,
        S_IDE,
        S_R0,
        S_DLC,
        S_DATA,
        S_CRC,
        S_CRC_DELIM,
        S_ACK,
        S_ACK_DELIM,
        S_EOF
    } state_t;

    localparam logic [2:0] ERR_STUFF = 3'd1;
    localparam logic [2:0] ERR_FORM  = 3'd2;
    localparam logic [2:0] ERR_CRC   = 3'd3;
    localparam logic [2:0] ERR_EXT   = 3'd4;

    localparam logic [6:0] L_INT_LAST = 7'(INTEGRATION_BITS - 1);
    localparam logic [6:0] L_EOF_LAST = 7'(EOF_BITS - 1);
    localparam logic [6:0] L_ID_LAST  = 7'd10;
    localparam logic [6:0] L_DLC_LAST = 7'd3;
    localparam logic [6:0] L_CRC_LAST = 7'd14;

    state_t      r_state;
    logic [6:0]  r_cnt;
    logic [6:0]  r_nbits;
    logic [14:0] r_crc;
    logic [14:0] r_crc_rx;
    logic [10:0] r_id;
    logic        r_rtr;
    logic [3:0]  r_dlc;
    logic [63:0] r_data;
    logic        r_fv;
    logic        r_ev;
    logic [2:0]  r_code;
    logic        r_busy;

    state_t      w_state_nx;
    logic [6:0]  w_cnt_nx;
    logic [6:0]  w_nbits_nx;
    logic [14:0] w_crc_nx;
    logic [14:0] w_crc_rx_nx;
    logic [10:0] w_id_nx;
    logic        w_rtr_nx;
    logic [3:0]  w_dlc_nx;
    logic [63:0] w_data_nx;
    logic        w_fv_nx;
    logic        w_ev_nx;
    logic [2:0]  w_code_nx;
    logic        w_busy_nx;

    logic        w_dse;
    logic        w_accept;
    logic        w_serr;
    logic        w_err;
    logic [2:0]  w_err_code;
    logic [14:0] w_crc_step;
    logic [6:0]  w_cnt_inc;
    logic [3:0]  w_dlc_full;
    logic [3:0]  w_nbytes;
    logic [5:0]  w_bitpos;

    // Stuffing region covers ID through the received CRC field.
    always_comb begin
        w_dse = 1'b0;
        unique case (r_state)
            S_ID, S_RTR, S_IDE, S_R0,
            S_DLC, S_DATA, S_CRC: w_dse = 1'b1;
            default:              w_dse = 1'b0;
        endcase
    end

    assign destuffing_enable = w_dse;
    assign ready             = rx_enable;
    assign ack_slot          = (r_state == S_ACK);

    assign rx_id       = r_id;
    assign rx_rtr      = r_rtr;
    assign rx_dlc      = r_dlc;
    assign rx_data     = r_data;
    assign frame_valid = r_fv;
    assign error_valid = r_ev;
    assign error_code  = r_code;
    assign busy        = r_busy;

    assign w_accept   = can_clk_en & bit_valid & rx_enable;
    assign w_serr     = can_clk_en & stuff_error & w_dse;
    assign w_cnt_inc  = r_cnt + 7'd1;
    assign w_dlc_full = {r_dlc[2:0], bit_in};
    assign w_bitpos   = 6'd63 - r_cnt[5:0];

    // Serial CRC-15 step on the current bit.
    assign w_crc_step = {r_crc[13:0], 1'b0}
                      ^ ((bit_in ^ r_crc[14]) ? CRC_POLY : 15'd0);

    // Remote frames carry no data; DLC values above 8 still mean 8 bytes.
    assign w_nbytes = r_rtr         ? 4'd0 :
                      w_dlc_full[3] ? 4'd8 : w_dlc_full;

    always_comb begin
        w_state_nx  = r_state;
        w_cnt_nx    = r_cnt;
        w_nbits_nx  = r_nbits;
        w_crc_nx    = r_crc;
        w_crc_rx_nx = r_crc_rx;
        w_id_nx     = r_id;
        w_rtr_nx    = r_rtr;
        w_dlc_nx    = r_dlc;
        w_data_nx   = r_data;
        w_fv_nx     = 1'b0;
        w_ev_nx     = 1'b0;
        w_code_nx   = r_code;
        w_busy_nx   = r_busy;
        w_err       = 1'b0;
        w_err_code  = 3'd0;

        if (can_clk_en && !rx_enable) begin
            // Disabling the receiver silently drops any frame in flight.
            w_state_nx = S_INTEGRATE;
            w_cnt_nx   = 7'd0;
            w_busy_nx  = 1'b0;
        end else if (w_serr) begin
            // A stuff error discards the bit offered in the same cycle.
            w_err      = 1'b1;
            w_err_code = ERR_STUFF;
        end else if (w_accept) begin
            unique case (r_state)
                S_INTEGRATE: begin
                    if (!bit_in) begin
                        w_cnt_nx = 7'd0;
                    end else if (r_cnt == L_INT_LAST) begin
                        w_cnt_nx   = 7'd0;
                        w_state_nx = S_IDLE;
                    end else begin
                        w_cnt_nx = w_cnt_inc;
                    end
                end
                S_IDLE: begin
                    if (!bit_in) begin
                        // SOF: a dominant bit into a cleared CRC leaves it zero.
                        w_crc_nx   = 15'd0;
                        w_data_nx  = 64'd0;
                        w_busy_nx  = 1'b1;
                        w_cnt_nx   = 7'd0;
                        w_state_nx = S_ID;
                    end
                end
                S_ID: begin
                    w_id_nx  = {r_id[9:0], bit_in};
                    w_crc_nx = w_crc_step;
                    if (r_cnt == L_ID_LAST) begin
                        w_cnt_nx   = 7'd0;
                        w_state_nx = S_RTR;
                    end else begin
                        w_cnt_nx = w_cnt_inc;
                    end
                end
                S_RTR: begin
                    w_rtr_nx   = bit_in;
                    w_crc_nx   = w_crc_step;
                    w_state_nx = S_IDE;
                end
                S_IDE: begin
                    w_crc_nx = w_crc_step;
                    if (bit_in) begin
                        w_err      = 1'b1;
                        w_err_code = ERR_EXT;
                    end else begin
                        w_state_nx = S_R0;
                    end
                end
                S_R0: begin
                    w_crc_nx   = w_crc_step;
                    w_cnt_nx   = 7'd0;
                    w_state_nx = S_DLC;
                end
                S_DLC: begin
                    w_dlc_nx = w_dlc_full;
                    w_crc_nx = w_crc_step;
                    if (r_cnt == L_DLC_LAST) begin
                        w_cnt_nx   = 7'd0;
                        w_nbits_nx = {w_nbytes, 3'b000};
                        w_state_nx = (w_nbytes == 4'd0) ? S_CRC : S_DATA;
                    end else begin
                        w_cnt_nx = w_cnt_inc;
                    end
                end
                S_DATA: begin
                    w_data_nx[w_bitpos] = bit_in;
                    w_crc_nx            = w_crc_step;
                    if (w_cnt_inc == r_nbits) begin
                        w_cnt_nx   = 7'd0;
                        w_state_nx = S_CRC;
                    end else begin
                        w_cnt_nx = w_cnt_inc;
                    end
                end
                S_CRC: begin
                    w_crc_rx_nx = {r_crc_rx[13:0], bit_in};
                    if (r_cnt == L_CRC_LAST) begin
                        w_cnt_nx   = 7'd0;
                        w_state_nx = S_CRC_DELIM;
                    end else begin
                        w_cnt_nx = w_cnt_inc;
                    end
                end
                S_CRC_DELIM: begin
                    if (!bit_in) begin
                        w_err      = 1'b1;
                        w_err_code = ERR_FORM;
                    end else if (r_crc_rx != r_crc) begin
                        w_err      = 1'b1;
                        w_err_code = ERR_CRC;
                    end else begin
                        w_state_nx = S_ACK;
                    end
                end
                S_ACK: begin
                    w_state_nx = S_ACK_DELIM;
                end
                S_ACK_DELIM: begin
                    if (!bit_in) begin
                        w_err      = 1'b1;
                        w_err_code = ERR_FORM;
                    end else begin
                        w_cnt_nx   = 7'd0;
                        w_state_nx = S_EOF;
                    end
                end
                S_EOF: begin
                    if (!bit_in) begin
                        w_err      = 1'b1;
                        w_err_code = ERR_FORM;
                    end else if (r_cnt == L_EOF_LAST) begin
                        w_fv_nx    = 1'b1;
                        w_busy_nx  = 1'b0;
                        w_cnt_nx   = 7'd0;
                        w_state_nx = S_IDLE;
                    end else begin
                        w_cnt_nx = w_cnt_inc;
                    end
                end
                default: begin
                    w_cnt_nx   = 7'd0;
                    w_state_nx = S_INTEGRATE;
                end
            endcase
        end

        // Every abort re-synchronises to the bus before the next SOF.
        if (w_err) begin
            w_ev_nx    = 1'b1;
            w_code_nx  = w_err_code;
            w_busy_nx  = 1'b0;
            w_cnt_nx   = 7'd0;
            w_state_nx = S_INTEGRATE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_INTEGRATE;
            r_cnt    <= 7'd0;
            r_nbits  <= 7'd0;
            r_crc    <= 15'd0;
            r_crc_rx <= 15'd0;
            r_id     <= 11'd0;
            r_rtr    <= 1'b0;
            r_dlc    <= 4'd0;
            r_data   <= 64'd0;
            r_fv     <= 1'b0;
            r_ev     <= 1'b0;
            r_code   <= 3'd0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_cnt    <= w_cnt_nx;
            r_nbits  <= w_nbits_nx;
            r_crc    <= w_crc_nx;
            r_crc_rx <= w_crc_rx_nx;
            r_id     <= w_id_nx;
            r_rtr    <= w_rtr_nx;
            r_dlc    <= w_dlc_nx;
            r_data   <= w_data_nx;
            r_fv     <= w_fv_nx;
            r_ev     <= w_ev_nx;
            r_code   <= w_code_nx;
            r_busy   <= w_busy_nx;
        end
    end

endmodule

// File: tb/tb_can_mac_rx_frame_sequencer.sv
// Testbench for can_mac_rx_frame_sequencer: frames are built as bit lists
// with a polynomial-division CRC and outcomes are checked by assertion.
module tb_can_mac_rx_frame_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        can_clk_en;
    logic        rx_enable;
    logic        bit_in;
    logic        bit_valid;
    logic        stuff_error;
    logic        destuffing_enable;
    logic        ready;
    logic [10:0] rx_id;
    logic        rx_rtr;
    logic [3:0]  rx_dlc;
    logic [63:0] rx_data;
    logic        frame_valid;
    logic        error_valid;
    logic [2:0]  error_code;
    logic        ack_slot;
    logic        busy;

    can_mac_rx_frame_sequencer dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .can_clk_en        (can_clk_en),
        .rx_enable         (rx_enable),
        .bit_in            (bit_in),
        .bit_valid         (bit_valid),
        .stuff_error       (stuff_error),
        .destuffing_enable (destuffing_enable),
        .ready             (ready),
        .rx_id             (rx_id),
        .rx_rtr            (rx_rtr),
        .rx_dlc            (rx_dlc),
        .rx_data           (rx_data),
        .frame_valid       (frame_valid),
        .error_valid       (error_valid),
        .error_code        (error_code),
        .ack_slot          (ack_slot),
        .busy              (busy)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    int fv_n, ev_n, ack_n, fv_at, ev_at, ack_at;
    int both_n = 0;
    int wide_n = 0;
    logic [2:0] ev_code;
    logic       ev_dse;
    logic       prev_fv = 1'b0;
    logic       prev_ev = 1'b0;
    int         drv_k = -1;

    bit          fq[$];
    logic [63:0] exp_data;
    int idx_data0, idx_delim, idx_ack, idx_ackdel, idx_eof;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic clear_obs();
        fv_n = 0; ev_n = 0; ack_n = 0;
        fv_at = -1; ev_at = -1; ack_at = -1;
        ev_code = 3'd0; ev_dse = 1'bx;
    endtask

    // One clock: sample what the previous drive produced, then drive anew.
    task automatic tick(input logic en, input logic v, input logic b,
                        input logic se, input int k);
        @(negedge clk);
        if (frame_valid) begin fv_n++; fv_at = drv_k; end
        if (error_valid) begin
            ev_n++; ev_at = drv_k; ev_code = error_code;
            ev_dse = destuffing_enable;
        end
        if (frame_valid && error_valid) both_n++;
        if ((frame_valid && prev_fv) || (error_valid && prev_ev)) wide_n++;
        prev_fv = frame_valid;
        prev_ev = error_valid;
        if (ack_slot && en && v) begin ack_n++; ack_at = k; end
        can_clk_en  = en;
        bit_valid   = v;
        bit_in      = b;
        stuff_error = se;
        drv_k       = k;
    endtask

    // Idle cycles between bits: either strobe-less noise or an empty strobe.
    task automatic gap();
        int n;
        n = $urandom_range(0, 2);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 1) == 1)
                tick(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), -1);
            else
                tick(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'b0, -1);
        end
    endtask

    task automatic settle();
        tick(1'b0, 1'b0, 1'b1, 1'b0, -1);
    endtask

    task automatic send1(input logic b);
        gap();
        tick(1'b1, 1'b1, b, 1'b0, -1);
    endtask

    task automatic integrate();
        for (int i = 0; i < 11; i++) send1(1'b1);
    endtask

    task automatic send_bits(input int stop, input int stuff_at, input int inv_at);
        for (int k = 0; k < stop; k++) begin
            gap();
            tick(1'b1, 1'b1, fq[k] ^ (k == inv_at), k == stuff_at, k);
        end
        settle();
        settle();
    endtask

    task automatic build_frame(input logic [10:0] id, input logic rtr,
                               input logic ide, input logic [3:0] dlc,
                               input logic [63:0] dat);
        bit          r[$];
        logic [15:0] g;
        logic [14:0] crc;
        int          nb, n;
        fq.delete();
        fq.push_back(1'b0);
        for (int i = 10; i >= 0; i--) fq.push_back(id[i]);
        fq.push_back(rtr);
        fq.push_back(ide);
        fq.push_back(1'($urandom_range(0, 1)));
        for (int i = 3; i >= 0; i--) fq.push_back(dlc[i]);
        idx_data0 = fq.size();
        nb = rtr ? 0 : ((dlc > 4'd8) ? 8 : int'(dlc));
        exp_data = 64'd0;
        for (int i = 0; i < nb * 8; i++) begin
            fq.push_back(dat[63 - i]);
            exp_data[63 - i] = dat[63 - i];
        end
        // CRC as remainder of message * x^15 divided by the generator.
        g = 16'hC599;
        r = fq;
        n = fq.size();
        repeat (15) r.push_back(1'b0);
        for (int i = 0; i < n; i++)
            if (r[i]) for (int j = 0; j < 16; j++) r[i + j] = r[i + j] ^ g[15 - j];
        for (int j = 0; j < 15; j++) crc[14 - j] = r[n + j];
        for (int j = 14; j >= 0; j--) fq.push_back(crc[j]);
        idx_delim = fq.size();
        fq.push_back(1'b1);
        idx_ack = fq.size();
        fq.push_back(1'b0);
        idx_ackdel = fq.size();
        fq.push_back(1'b1);
        idx_eof = fq.size();
        repeat (7) fq.push_back(1'b1);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        can_clk_en = 1'b0; bit_valid = 1'b0; bit_in = 1'b1; stuff_error = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic good_frame(input string tag, input logic [10:0] id,
                              input logic rtr, input logic [3:0] dlc,
                              input logic [63:0] dat);
        build_frame(id, rtr, 1'b0, dlc, dat);
        clear_obs();
        send_bits(fq.size(), -1, -1);
        check({tag, "_fv"}, 64'(fv_n), 64'd1);
        check({tag, "_ev"}, 64'(ev_n), 64'd0);
        check({tag, "_id"}, 64'(rx_id), 64'(id));
        check({tag, "_rtr"}, 64'(rx_rtr), 64'(rtr));
        check({tag, "_dlc"}, 64'(rx_dlc), 64'(dlc));
        check({tag, "_data"}, rx_data, exp_data);
    endtask

    initial begin
        rx_enable = 1'b1;
        do_reset();
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_fv", 64'(frame_valid), 64'd0);
        check("rst_ev", 64'(error_valid), 64'd0);
        check("rst_code", 64'(error_code), 64'd0);
        check("rst_id", 64'(rx_id), 64'd0);
        check("rst_dlc", 64'(rx_dlc), 64'd0);
        check("rst_data", rx_data, 64'd0);
        check("rst_ack", 64'(ack_slot), 64'd0);
        check("rst_dse", 64'(destuffing_enable), 64'd0);
        check("rst_ready", 64'(ready), 64'd1);

        // Basic frame ID=0x123, data A5 5A.
        integrate();
        good_frame("f123", 11'h123, 1'b0, 4'd2, 64'hA55A_0000_0000_0000);
        check("f123_fv_at", 64'(fv_at), 64'(fq.size() - 1));
        check("f123_ack_n", 64'(ack_n), 64'd1);
        check("f123_ack_at", 64'(ack_at), 64'(idx_ack));
        check("f123_busy", 64'(busy), 64'd0);

        // CRC bit 0 inverted.
        build_frame(11'h123, 1'b0, 1'b0, 4'd2, 64'hA55A_0000_0000_0000);
        clear_obs();
        send_bits(fq.size(), -1, idx_delim - 1);
        check("crc_ev", 64'(ev_n), 64'd1);
        check("crc_code", 64'(ev_code), 64'd3);
        check("crc_at", 64'(ev_at), 64'(idx_delim));
        check("crc_fv", 64'(fv_n), 64'd0);
        check("crc_ack", 64'(ack_n), 64'd0);
        integrate();
        good_frame("after_crc", 11'h3A7, 1'b0, 4'd3, 64'h1234_5600_0000_0000);

        // Random frames.
        for (int r = 0; r < 6; r++)
            good_frame("rand", 11'($urandom_range(0, 2047)),
                       ($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)),
                       {$urandom, $urandom});

        // Stuff error at DATA bit 5 with a valid bit in the same cycle.
        build_frame(11'h055, 1'b0, 1'b0, 4'd1, 64'hFF00_0000_0000_0000);
        clear_obs();
        send_bits(idx_data0 + 6, idx_data0 + 5, -1);
        check("stf_ev", 64'(ev_n), 64'd1);
        check("stf_code", 64'(ev_code), 64'd1);
        check("stf_at", 64'(ev_at), 64'(idx_data0 + 5));
        check("stf_dse", 64'(ev_dse), 64'd0);
        check("stf_data", rx_data, 64'hF800_0000_0000_0000);
        send1(1'b0);
        settle();
        check("stf_integrate", 64'(busy), 64'd0);

        // Extended frame.
        integrate();
        build_frame(11'h7FF, 1'b0, 1'b1, 4'd0, 64'd0);
        clear_obs();
        send_bits(fq.size(), -1, -1);
        check("ide_code", 64'(ev_code), 64'd4);
        check("ide_at", 64'(ev_at), 64'd13);
        check("ide_fv", 64'(fv_n), 64'd0);

        integrate();
        good_frame("dlc15", 11'h2C1, 1'b0, 4'd15, {$urandom, $urandom});
        good_frame("rtr", 11'h0F0, 1'b1, 4'd4, {$urandom, $urandom});
        check("rtr_fv_at", 64'(fv_at), 64'(fq.size() - 1));

        // Dominant in EOF bit 3.
        build_frame(11'h111, 1'b0, 1'b0, 4'd1, 64'h3C00_0000_0000_0000);
        clear_obs();
        send_bits(fq.size(), -1, idx_eof + 2);
        check("eof_code", 64'(ev_code), 64'd2);
        check("eof_at", 64'(ev_at), 64'(idx_eof + 2));
        check("eof_fv", 64'(fv_n), 64'd0);

        // Dominant ACK delimiter.
        integrate();
        build_frame(11'h222, 1'b0, 1'b0, 4'd0, 64'd0);
        clear_obs();
        send_bits(fq.size(), -1, idx_ackdel);
        check("ackd_code", 64'(ev_code), 64'd2);
        check("ackd_at", 64'(ev_at), 64'(idx_ackdel));
        check("ackd_ack", 64'(ack_n), 64'd1);

        // Integration restart.
        do_reset();
        repeat (6) send1(1'b1);
        send1(1'b0);
        repeat (10) send1(1'b1);
        settle();
        check("int10_busy", 64'(busy), 64'd0);
        send1(1'b0);
        settle();
        check("int_nosof", 64'(busy), 64'd0);
        integrate();
        send1(1'b0);
        settle();
        check("int_sof", 64'(busy), 64'd1);
        check("int_dse", 64'(destuffing_enable), 64'd1);

        // rx_enable dropped mid-DATA; a stuff error in that strobe is overridden.
        do_reset();
        integrate();
        build_frame(11'h5A5, 1'b0, 1'b0, 4'd4, {$urandom, $urandom});
        clear_obs();
        send_bits(idx_data0 + 10, -1, -1);
        check("en_busy_before", 64'(busy), 64'd1);
        rx_enable = 1'b0;
        #1;
        check("en_ready", 64'(ready), 64'd0);
        tick(1'b1, 1'b1, 1'b0, 1'b1, -1);
        settle();
        settle();
        check("en_busy", 64'(busy), 64'd0);
        check("en_dse", 64'(destuffing_enable), 64'd0);
        check("en_ev", 64'(ev_n), 64'd0);
        check("en_fv", 64'(fv_n), 64'd0);
        rx_enable = 1'b1;

        // Reset mid-ID.
        integrate();
        build_frame(11'h7F0, 1'b0, 1'b0, 4'd1, 64'd0);
        send_bits(6, -1, -1);
        check("mid_busy", 64'(busy), 64'd1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_id", 64'(rx_id), 64'd0);
        check("mid_rst_data", rx_data, 64'd0);
        check("mid_rst_dse", 64'(destuffing_enable), 64'd0);
        check("mid_rst_pulse", 64'({frame_valid, error_valid}), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        settle();

        check("both_pulses", 64'(both_n), 64'd0);
        check("pulse_width", 64'(wide_n), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
